pipe_hazard_ctrl: RTL

Interlock and forwarding controller for the five-stage pipeline, evaluated alongside the ID stage. It keeps its own shadow records of the destination registers in flight in EX and MEM, and from them drives the operand forwarding selects for the ID operand muxes. It stalls PC/IF/ID on load-use hazards and, optionally, while a multi-cycle multiply/divide is still busy.

---
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use interlock and EX/MEM operand forwarding evaluated alongside ID.
// Define PIPE_HAZ_MULDIV_EN to build the multiply/divide busy counter and its HI/LO stall.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LAT = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_wreg,
    input  logic [4:0] id_rn,
    input  logic       id_m2reg,
    input  logic       id_md_start,
    input  logic       id_md_use,
    output logic       stall,
    output logic [1:0] fwda,
    output logic [1:0] fwdb,
    output logic       md_busy
);

    logic       ex_wreg;
    logic [4:0] ex_rn;
    logic       ex_m2reg;
    logic       mem_wreg;
    logic [4:0] mem_rn;
    logic       mem_m2reg;

    logic       ex_hit_a;
    logic       ex_hit_b;
    logic       mem_hit_a;
    logic       mem_hit_b;
    logic       lu_stall;
    logic       md_stall;
    logic       id_eff;

    function automatic logic src_match(
        input logic       used,
        input logic [4:0] src,
        input logic       wreg,
        input logic [4:0] rn
    );
        return used && (src != 5'd0) && wreg && (rn == src);
    endfunction

    // A load sitting in EX cannot forward yet; that operand is held at 00 while stalling.
    function automatic logic [1:0] fwd_sel(
        input logic ex_hit,
        input logic ex_ld,
        input logic mem_hit,
        input logic mem_ld
    );
        if (ex_hit)
            return ex_ld ? 2'b00 : 2'b01;
        if (mem_hit)
            return mem_ld ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        ex_hit_a  = src_match(id_use_rs, id_rs, ex_wreg,  ex_rn);
        ex_hit_b  = src_match(id_use_rt, id_rt, ex_wreg,  ex_rn);
        mem_hit_a = src_match(id_use_rs, id_rs, mem_wreg, mem_rn);
        mem_hit_b = src_match(id_use_rt, id_rt, mem_wreg, mem_rn);
        fwda      = fwd_sel(ex_hit_a, ex_m2reg, mem_hit_a, mem_m2reg);
        fwdb      = fwd_sel(ex_hit_b, ex_m2reg, mem_hit_b, mem_m2reg);
        lu_stall  = (ex_hit_a | ex_hit_b) & ex_m2reg;
        stall     = id_valid & (lu_stall | md_stall);
        id_eff    = id_valid & ~stall;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_wreg   <= 1'b0;
            ex_rn     <= '0;
            ex_m2reg  <= 1'b0;
            mem_wreg  <= 1'b0;
            mem_rn    <= '0;
            mem_m2reg <= 1'b0;
        end else begin
            if (id_eff) begin
                ex_wreg  <= id_wreg;
                ex_rn    <= id_rn;
                ex_m2reg <= id_m2reg;
            end else begin
                ex_wreg  <= 1'b0;
                ex_rn    <= '0;
                ex_m2reg <= 1'b0;
            end
            mem_wreg  <= ex_wreg;
            mem_rn    <= ex_rn;
            mem_m2reg <= ex_m2reg;
        end
    end

`ifdef PIPE_HAZ_MULDIV_EN
    logic [3:0] md_cnt;

    always_ff @(posedge clock) begin
        if (reset)
            md_cnt <= '0;
        else if (id_eff && id_md_start)
            md_cnt <= 4'(MD_LAT);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 4'd1;
    end

    always_comb begin
        md_busy  = (md_cnt != '0);
        md_stall = id_md_use & md_busy;
    end
`else
    logic [5:0] unused_md;

    always_comb begin
        unused_md = {id_md_start, id_md_use, 4'(MD_LAT)};
        md_busy   = 1'b0;
        md_stall  = 1'b0;
    end
`endif

endmodule
